keypad_debounce_encoder: RTL and testbench



---
 rtl/keypad_debounce_encoder.sv | 179 +++++++++++++++++
 tb/tb_keypad_debounce_encoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_debounce_encoder.sv
// Keypad front end: 2-flop sync, debounce, multi-key reject, one-hot to code; strobe DEBOUNCE_CYCLES+3 edges after a stable press.
// Optional auto-repeat of the strobe while a key is held is compiled in with KEYPAD_AUTOREPEAT_EN.
module keypad_debounce_encoder #(
  parameter int N_KEYS          = 12,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_in,
  output logic [3:0]        keypad_value,
  output logic              keypad_enable,
  output logic              key_held,
  output logic              multi_press
);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif
  localparam int CNT_MAX = (AUTOREPEAT && REPEAT_CYCLES > DEBOUNCE_CYCLES) ? REPEAT_CYCLES
                                                                           : DEBOUNCE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE, DEBOUNCE, PRESSED, RELEASE, REJECT, REJECT_RELEASE
  } state_t;

  state_t            state, state_nxt;
  logic [N_KEYS-1:0] s1, s2;
  logic [N_KEYS-1:0] cand, cand_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [3:0]        value_nxt;
  logic              enable_nxt, held_nxt, multi_nxt;
  logic [4:0]        n_set;
  logic [3:0]        code;
  logic              one_hot, cnt_done, s2_zero, s2_same;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  // Population count and encoded index of the candidate vector.
  always_comb begin
    n_set = 5'd0;
    code  = 4'd0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (cand[i]) begin
        n_set = n_set + 5'd1;
        code  = 4'(i + 1);
      end
    end
  end

  assign one_hot  = (n_set == 5'd1);
  assign cnt_done = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign s2_zero  = (s2 == '0);
  assign s2_same  = (s2 == cand);

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    value_nxt  = keypad_value;
    enable_nxt = 1'b0;
    held_nxt   = key_held;
    multi_nxt  = multi_press;
    case (state)
      IDLE: begin
        if (!s2_zero) begin
          cand_nxt  = s2;
          cnt_nxt   = '0;
          state_nxt = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!s2_same) begin
          state_nxt = IDLE;
        end else if (cnt_done) begin
          cnt_nxt = '0;
          if (one_hot) begin
            state_nxt  = PRESSED;
            value_nxt  = code;
            enable_nxt = 1'b1;
            held_nxt   = 1'b1;
          end else begin
            state_nxt = REJECT;
            multi_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s2_same) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          if (cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
            enable_nxt = 1'b1;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
`else
          cnt_nxt = cnt;
`endif
        end
      end
      RELEASE: begin
        // Returning to the same key is a glitch, not a new press: no strobe.
        if (s2_same) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (s2_zero) begin
          if (cnt_done) begin
            state_nxt = IDLE;
            held_nxt  = 1'b0;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      REJECT: begin
        if (!s2_same) begin
          state_nxt = REJECT_RELEASE;
          cnt_nxt   = '0;
        end
      end
      REJECT_RELEASE: begin
        // Same qualification as RELEASE, but no way back to a held state.
        if (s2_zero) begin
          if (cnt_done) begin
            state_nxt = IDLE;
            multi_nxt = 1'b0;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else begin
          cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cand          <= '0;
      cnt           <= '0;
      keypad_value  <= 4'd0;
      keypad_enable <= 1'b0;
      key_held      <= 1'b0;
      multi_press   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cand          <= cand_nxt;
      cnt           <= cnt_nxt;
      keypad_value  <= value_nxt;
      keypad_enable <= enable_nxt;
      key_held      <= held_nxt;
      multi_press   <= multi_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Directed bench for keypad_debounce_encoder with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Expected values follow the edge numbering where edge 0 first samples the new key vector.
module tb_keypad_debounce_encoder;

  localparam int NK = 12;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic AR = 1'b1;
`else
  localparam logic AR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_in;
  logic [3:0]    keypad_value;
  logic          keypad_enable;
  logic          key_held;
  logic          multi_press;

  int vectors     = 0;
  int miscompares = 0;
  int strobes     = 0;
  int s0;

  keypad_debounce_encoder #(
    .N_KEYS(NK),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_in(key_in),
    .keypad_value(keypad_value),
    .keypad_enable(keypad_enable),
    .key_held(key_held),
    .multi_press(multi_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (keypad_enable) strobes <= strobes + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset  = 1'b1;
    key_in = '0;
    step(2);
    chk("rst_value", 32'(keypad_value), 0);
    chk("rst_enable", 32'(keypad_enable), 0);
    chk("rst_held", 32'(key_held), 0);
    chk("rst_multi", 32'(multi_press), 0);
    reset = 1'b0;
    step(2);

    // Clean press of key 2, held through edge 19.
    s0 = strobes;
    key_in = 12'h004;
    step(6);
    chk("clean_no_early_strobe", 32'(keypad_enable), 0);
    step(1);
    chk("clean_strobe_e6", 32'(keypad_enable), 1);
    chk("clean_value", 32'(keypad_value), 3);
    chk("clean_held", 32'(key_held), 1);
    step(1);
    chk("clean_strobe_single_cycle", 32'(keypad_enable), 0);
    step(7);
    chk("clean_repeat_e14", 32'(keypad_enable), 32'(AR));
    step(5);
    chk("clean_strobe_count", 32'(strobes - s0), AR ? 2 : 1);
    key_in = '0;
    step(6);
    chk("clean_held_before_release", 32'(key_held), 1);
    step(1);
    chk("clean_held_released_e6", 32'(key_held), 0);
    chk("clean_value_retained", 32'(keypad_value), 3);

    // Bounce on key 0: high2 low2 high2 low2 then held from edge 8.
    step(3);
    s0 = strobes;
    key_in = 12'h001; step(2);
    key_in = 12'h000; step(2);
    key_in = 12'h001; step(2);
    key_in = 12'h000; step(2);
    key_in = 12'h001;
    step(6);
    chk("bounce_no_strobe", 32'(strobes - s0), 0);
    chk("bounce_enable_e13", 32'(keypad_enable), 0);
    step(1);
    chk("bounce_strobe_e14", 32'(keypad_enable), 1);
    chk("bounce_value", 32'(keypad_value), 1);
    key_in = '0;
    step(8);
    chk("bounce_released", 32'(key_held), 0);

    // Multi-key: keys 1 and 4 together.
    s0 = strobes;
    key_in = 12'h012;
    step(6);
    chk("multi_not_yet", 32'(multi_press), 0);
    step(1);
    chk("multi_set_e6", 32'(multi_press), 1);
    chk("multi_no_held", 32'(key_held), 0);
    step(4);
    key_in = '0;
    step(6);
    chk("multi_still_set", 32'(multi_press), 1);
    step(1);
    chk("multi_clear_e6", 32'(multi_press), 0);
    chk("multi_no_strobe", 32'(strobes - s0), 0);
    chk("multi_value_retained", 32'(keypad_value), 1);
    key_in = 12'h010;
    step(7);
    chk("after_multi_strobe", 32'(keypad_enable), 1);
    chk("after_multi_value", 32'(keypad_value), 5);
    key_in = '0;
    step(8);

    // Release glitch on key 6.
    key_in = 12'h040;
    step(7);
    chk("glitch_strobe", 32'(keypad_enable), 1);
    chk("glitch_value", 32'(keypad_value), 7);
    step(1);
    s0 = strobes;
    key_in = '0;
    step(2);
    key_in = 12'h040;
    step(8);
    chk("glitch_held", 32'(key_held), 1);
    chk("glitch_no_restrobe", 32'(strobes - s0), 0);
    key_in = '0;
    step(8);
    chk("glitch_released", 32'(key_held), 0);

    // Reset at edge 4 of a key 0 press that stays held.
    key_in = 12'h001;
    step(4);
    reset = 1'b1;
    step(1);
    chk("mid_rst_value", 32'(keypad_value), 0);
    chk("mid_rst_enable", 32'(keypad_enable), 0);
    chk("mid_rst_held", 32'(key_held), 0);
    chk("mid_rst_multi", 32'(multi_press), 0);
    reset = 1'b0;
    s0 = strobes;
    step(6);
    chk("post_rst_no_early", 32'(keypad_enable), 0);
    step(1);
    chk("post_rst_strobe", 32'(keypad_enable), 1);
    chk("post_rst_value", 32'(keypad_value), 1);
    step(1);
    chk("post_rst_one_strobe", 32'(strobes - s0), 1);
    key_in = '0;
    step(8);

    // Long hold of key 3: repeats only with the auto-repeat build.
    key_in = 12'h008;
    step(7);
    chk("hold_strobe_e6", 32'(keypad_enable), 1);
    chk("hold_value", 32'(keypad_value), 4);
    step(8);
    chk("hold_repeat_e14", 32'(keypad_enable), 32'(AR));
    step(8);
    chk("hold_repeat_e22", 32'(keypad_enable), 32'(AR));
    chk("hold_value_e22", 32'(keypad_value), 4);
    key_in = '0;
    step(8);
    chk("hold_released", 32'(key_held), 0);
    chk("hold_value_kept", 32'(keypad_value), 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
